// File: rtl/ll_refine_pkg.sv
// Shared constants and the slot-entry type for the linked-list refinement tracker.
package ll_refine_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_NUM_FIFOS = 2;
  localparam int DEF_FIFO_SEL  = 0;
  localparam int DEF_PTR_WIDTH = $clog2(DEF_DEPTH);

  // One tracked physical slot at the default geometry.
  typedef struct packed {
    logic                     valid;
    logic [DEF_PTR_WIDTH-1:0] idx;
    logic [DEF_WIDTH-1:0]     data;
  } slot_entry_t;

endpackage

// File: rtl/ll_refine_slot.sv
// One physical slot: holds valid, logical index and (with LL_REFINE_DATA_EN) data.
module ll_refine_slot #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic                 pop,
  input  logic [PTR_WIDTH-1:0] set_idx,
  input  logic [WIDTH-1:0]     set_data,
  output logic                 valid,
  output logic [PTR_WIDTH-1:0] idx,
  output logic [WIDTH-1:0]     data
);

  localparam logic [PTR_WIDTH-1:0] IDX_ONE = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  // A set wins over a pop so the slot freed at the head can be reused in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      idx   <= '0;
    end else if (set) begin
      valid <= 1'b1;
      idx   <= set_idx;
    end else if (pop && valid) begin
      if (idx == '0) begin
        valid <= 1'b0;
        idx   <= '0;
      end else begin
        idx <= idx - IDX_ONE;
      end
    end
  end

`ifdef LL_REFINE_DATA_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (set) begin
      data <= set_data;
    end
  end
`else
  logic unused_data;
  assign unused_data = ^set_data;
  assign data        = '0;
`endif

endmodule

// File: rtl/ll_upward_refinement.sv
// Abstract-queue view of one logical FIFO inside a shared linked-list FIFO.
// Optional per-slot data storage is enabled by defining LL_REFINE_DATA_EN.
module ll_upward_refinement
  import ll_refine_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int FIFO_SEL  = DEF_FIFO_SEL,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [SEL_WIDTH-1:0] push_sel,
  input  logic [SEL_WIDTH-1:0] pop_sel,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [PTR_WIDTH-1:0] alloc_ptr,
  input  logic [PTR_WIDTH-1:0] query_ptr,
  input  logic [PTR_WIDTH-1:0] query_idx,
  output logic                 abs_empty,
  output logic                 abs_full,
  output logic [PTR_WIDTH:0]   abs_count,
  output logic [PTR_WIDTH-1:0] idx_of_ptr,
  output logic                 ptr_vld,
  output logic [PTR_WIDTH-1:0] ptr_of_idx,
  output logic                 idx_vld,
  output logic [WIDTH-1:0]     abs_data_out,
  output logic                 err
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [DEPTH-1:0]     s_valid;
  logic [PTR_WIDTH-1:0] s_idx  [DEPTH];
  logic [WIDTH-1:0]     s_data [DEPTH];
  logic [DEPTH-1:0]     s_set;

  logic [PTR_WIDTH:0]   count;
  logic                 err_q;

  logic                 t_push, t_pop, do_pop, push_ok;
  logic                 alloc_valid, alloc_head;
  logic                 err_pop, err_full, err_alloc;
  logic [PTR_WIDTH:0]   push_pos;

  assign t_push = push && (push_sel == SEL_WIDTH'(FIFO_SEL));
  assign t_pop  = pop  && (pop_sel  == SEL_WIDTH'(FIFO_SEL));
  assign do_pop = t_pop && (count != '0);

  always_comb begin
    alloc_valid = 1'b0;
    alloc_head  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PTR_WIDTH'(i) == alloc_ptr) begin
        alloc_valid = s_valid[i];
        alloc_head  = s_valid[i] && (s_idx[i] == '0);
      end
    end
  end

  // Reusing the slot that the same-cycle pop frees at the head is legal.
  assign err_pop   = t_pop && (count == '0);
  assign err_full  = t_push && (count == DEPTH_C) && !do_pop;
  assign err_alloc = t_push && alloc_valid && !(do_pop && alloc_head);
  assign push_ok   = t_push && !err_full && !err_alloc;
  assign push_pos  = do_pop ? (count - CNT_ONE) : count;

  always_comb begin
    s_set = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s_set[i] = push_ok && (PTR_WIDTH'(i) == alloc_ptr);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    ll_refine_slot #(
      .WIDTH     (WIDTH),
      .PTR_WIDTH (PTR_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .set      (s_set[g]),
      .pop      (do_pop),
      .set_idx  (push_pos[PTR_WIDTH-1:0]),
      .set_data (data_in),
      .valid    (s_valid[g]),
      .idx      (s_idx[g]),
      .data     (s_data[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err_q <= 1'b0;
    end else begin
      if (push_ok && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (do_pop && !push_ok) begin
        count <= count - CNT_ONE;
      end
      if (err_pop || err_full || err_alloc) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    idx_of_ptr   = '0;
    ptr_vld      = 1'b0;
    ptr_of_idx   = '0;
    abs_data_out = '0;
    idx_vld      = ({1'b0, query_idx} < count);
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_WIDTH'(i) == query_ptr) && s_valid[i]) begin
        idx_of_ptr = s_idx[i];
        ptr_vld    = 1'b1;
      end
      if (idx_vld && s_valid[i] && (s_idx[i] == query_idx)) begin
        ptr_of_idx = PTR_WIDTH'(i);
      end
      if (s_valid[i] && (s_idx[i] == '0)) begin
        abs_data_out = s_data[i];
      end
    end
  end

  assign abs_count = count;
  assign abs_empty = (count == '0);
  assign abs_full  = (count == DEPTH_C);
  assign err       = err_q;

endmodule

// File: tb/tb_ll_upward_refinement.sv
// Directed self-checking bench for ll_upward_refinement (default geometry).
module tb_ll_upward_refinement;

`ifdef LL_REFINE_DATA_EN
  localparam bit DATA_EN = 1'b1;
`else
  localparam bit DATA_EN = 1'b0;
`endif

  logic       clk, rst, push, pop;
  logic [0:0] push_sel, pop_sel;
  logic [7:0] data_in;
  logic [1:0] alloc_ptr, query_ptr, query_idx;
  logic       abs_empty, abs_full, ptr_vld, idx_vld, err;
  logic [2:0] abs_count;
  logic [1:0] idx_of_ptr, ptr_of_idx;
  logic [7:0] abs_data_out;

  int n_checks = 0;
  int n_pass   = 0;

  ll_upward_refinement dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .push_sel     (push_sel),
    .pop_sel      (pop_sel),
    .data_in      (data_in),
    .alloc_ptr    (alloc_ptr),
    .query_ptr    (query_ptr),
    .query_idx    (query_idx),
    .abs_empty    (abs_empty),
    .abs_full     (abs_full),
    .abs_count    (abs_count),
    .idx_of_ptr   (idx_of_ptr),
    .ptr_vld      (ptr_vld),
    .ptr_of_idx   (ptr_of_idx),
    .idx_vld      (idx_vld),
    .abs_data_out (abs_data_out),
    .err          (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Driver: one cycle of push and/or pop, strobes dropped afterwards.
  task automatic op(input logic p, input logic [0:0] ps, input logic [1:0] ap,
                    input logic [7:0] d, input logic q, input logic [0:0] qs);
    push = p; push_sel = ps; alloc_ptr = ap; data_in = d;
    pop = q; pop_sel = qs;
    step();
    push = 1'b0; pop = 1'b0;
  endtask

  function automatic logic [7:0] exp_data(input logic [7:0] v);
    return DATA_EN ? v : 8'h00;
  endfunction

  task automatic chk_ptr(input string name, input logic [1:0] qp,
                         input logic e_vld, input logic [1:0] e_idx);
    query_ptr = qp;
    #1;
    n_checks++;
    if (ptr_vld !== e_vld || idx_of_ptr !== e_idx)
      $display("FAIL %s ptr=%0d: got vld=%b idx=%0d, expected vld=%b idx=%0d",
               name, qp, ptr_vld, idx_of_ptr, e_vld, e_idx);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (abs_empty !== 1'b1 || abs_full !== 1'b0 || abs_count !== 3'd0 || err !== 1'b0 ||
        abs_data_out !== 8'h00)
      $display("FAIL reset_state: got empty=%b full=%b count=%0d err=%b data=%h, expected 1 0 0 0 00",
               abs_empty, abs_full, abs_count, err, abs_data_out);
    else n_pass++;
    for (int i = 0; i < 4; i++) chk_ptr("reset_ptr", 2'(i), 1'b0, 2'd0);
    query_idx = 2'd0;
    #1;
    n_checks++;
    if (idx_vld !== 1'b0 || ptr_of_idx !== 2'd0)
      $display("FAIL reset_idx: got vld=%b ptr=%0d, expected 0 0", idx_vld, ptr_of_idx);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if (abs_empty !== 1'b1 || err !== 1'b0)
      $display("FAIL idle: got empty=%b err=%b, expected 1 0", abs_empty, err);
    else n_pass++;
  endtask

  task automatic test_push_order();
    op(1, 0, 2'd2, 8'hA1, 0, 0);
    op(1, 0, 2'd0, 8'hB2, 0, 0);
    op(1, 0, 2'd3, 8'hC3, 0, 0);
    query_idx = 2'd1;
    #1;
    n_checks++;
    if (abs_count !== 3'd3 || idx_vld !== 1'b1 || ptr_of_idx !== 2'd0)
      $display("FAIL push3: got count=%0d vld=%b ptr=%0d, expected 3 1 0",
               abs_count, idx_vld, ptr_of_idx);
    else n_pass++;
    chk_ptr("push3_ptr3", 2'd3, 1'b1, 2'd2);
    n_checks++;
    if (abs_data_out !== exp_data(8'hA1))
      $display("FAIL push3_head: got %h expected %h", abs_data_out, exp_data(8'hA1));
    else n_pass++;
    query_idx = 2'd3;
    #1;
    n_checks++;
    if (idx_vld !== 1'b0 || ptr_of_idx !== 2'd0)
      $display("FAIL idx_oob: got vld=%b ptr=%0d, expected 0 0", idx_vld, ptr_of_idx);
    else n_pass++;
  endtask

  task automatic test_pop();
    op(0, 0, 2'd0, 8'h00, 1, 0);
    n_checks++;
    if (abs_count !== 3'd2 || abs_data_out !== exp_data(8'hB2))
      $display("FAIL pop: got count=%0d data=%h, expected 2 %h",
               abs_count, abs_data_out, exp_data(8'hB2));
    else n_pass++;
    chk_ptr("pop_ptr2", 2'd2, 1'b0, 2'd0);
    chk_ptr("pop_ptr0", 2'd0, 1'b1, 2'd0);
    chk_ptr("pop_ptr3", 2'd3, 1'b1, 2'd1);
  endtask

  task automatic test_full_push_pop();
    op(1, 0, 2'd1, 8'hE5, 0, 0);
    op(1, 0, 2'd2, 8'hF6, 0, 0);
    n_checks++;
    if (abs_count !== 3'd4 || abs_full !== 1'b1 || abs_empty !== 1'b0)
      $display("FAIL fill: got count=%0d full=%b empty=%b, expected 4 1 0",
               abs_count, abs_full, abs_empty);
    else n_pass++;
    // Head is slot 0; reuse it for the push half.
    op(1, 0, 2'd0, 8'hD4, 1, 0);
    n_checks++;
    if (abs_count !== 3'd4 || err !== 1'b0 || abs_data_out !== exp_data(8'hC3))
      $display("FAIL push_pop_full: got count=%0d err=%b data=%h, expected 4 0 %h",
               abs_count, err, abs_data_out, exp_data(8'hC3));
    else n_pass++;
    chk_ptr("pp_ptr0", 2'd0, 1'b1, 2'd3);
    chk_ptr("pp_ptr3", 2'd3, 1'b1, 2'd0);
    chk_ptr("pp_ptr1", 2'd1, 1'b1, 2'd1);
    chk_ptr("pp_ptr2", 2'd2, 1'b1, 2'd2);
    query_idx = 2'd3;
    #1;
    n_checks++;
    if (idx_vld !== 1'b1 || ptr_of_idx !== 2'd0)
      $display("FAIL pp_idx3: got vld=%b ptr=%0d, expected 1 0", idx_vld, ptr_of_idx);
    else n_pass++;
  endtask

  task automatic test_ignored();
    op(1, 1, 2'd1, 8'h77, 1, 1);
    n_checks++;
    if (abs_count !== 3'd4 || err !== 1'b0 || abs_data_out !== exp_data(8'hC3))
      $display("FAIL other_fifo: got count=%0d err=%b data=%h, expected 4 0 %h",
               abs_count, err, abs_data_out, exp_data(8'hC3));
    else n_pass++;
    chk_ptr("other_ptr1", 2'd1, 1'b1, 2'd1);
  endtask

  task automatic test_errors();
    op(1, 0, 2'd1, 8'h11, 0, 0);
    n_checks++;
    if (err !== 1'b1 || abs_count !== 3'd4)
      $display("FAIL err_full: got err=%b count=%0d, expected 1 4", err, abs_count);
    else n_pass++;

    do_reset();
    op(0, 0, 2'd0, 8'h00, 1, 0);
    n_checks++;
    if (err !== 1'b1 || abs_count !== 3'd0 || abs_empty !== 1'b1)
      $display("FAIL err_pop_empty: got err=%b count=%0d empty=%b, expected 1 0 1",
               err, abs_count, abs_empty);
    else n_pass++;
    step();
    step();
    n_checks++;
    if (err !== 1'b1)
      $display("FAIL err_sticky: got %b expected 1", err);
    else n_pass++;

    do_reset();
    n_checks++;
    if (err !== 1'b0)
      $display("FAIL err_cleared: got %b expected 0", err);
    else n_pass++;
    op(1, 0, 2'd1, 8'hA1, 0, 0);
    op(1, 0, 2'd1, 8'h5A, 0, 0);
    n_checks++;
    if (err !== 1'b1 || abs_count !== 3'd1 || abs_data_out !== exp_data(8'hA1))
      $display("FAIL err_realloc: got err=%b count=%0d data=%h, expected 1 1 %h",
               err, abs_count, abs_data_out, exp_data(8'hA1));
    else n_pass++;

    do_reset();
    op(1, 0, 2'd2, 8'h3C, 1, 0);
    n_checks++;
    if (err !== 1'b1 || abs_count !== 3'd1 || abs_data_out !== exp_data(8'h3C))
      $display("FAIL err_pushpop_empty: got err=%b count=%0d data=%h, expected 1 1 %h",
               err, abs_count, abs_data_out, exp_data(8'h3C));
    else n_pass++;
    chk_ptr("pp_empty_ptr2", 2'd2, 1'b1, 2'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    op(1, 0, 2'd0, 8'h01, 0, 0);
    op(1, 0, 2'd1, 8'h02, 0, 0);
    @(negedge clk);
    push = 1'b1; push_sel = 1'b0; alloc_ptr = 2'd3; data_in = 8'h03;
    rst = 1'b1;
    #1;
    n_checks++;
    if (abs_count !== 3'd0 || abs_empty !== 1'b1)
      $display("FAIL rst_async: got count=%0d empty=%b, expected 0 1", abs_count, abs_empty);
    else n_pass++;
    step();
    push = 1'b0;
    rst  = 1'b0;
    step();
    n_checks++;
    if (abs_count !== 3'd0 || err !== 1'b0)
      $display("FAIL rst_discard: got count=%0d err=%b, expected 0 0", abs_count, err);
    else n_pass++;
    chk_ptr("rst_ptr3", 2'd3, 1'b0, 2'd0);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_sel = 1'b0; pop_sel = 1'b0;
    data_in = 8'h00; alloc_ptr = 2'd0; query_ptr = 2'd0; query_idx = 2'd0;
    test_reset();
    test_push_order();
    test_pop();
    test_full_push_pop();
    test_ignored();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
